control_minado: RTL and testbench
=================================

Name: control_minado

Overview:
- Search controller directly downstream of comparador_target_hash.
- Issues the nonce sequence to the hash datapath and aligns each comparator result with the nonce that produced it, allowing for the datapath's pipeline latency.
- Captures the first winning nonce and hash, then presents them on a valid/ack handshake to the system interface.
- Reports exhaustion when the nonce range is used up without a hit.

Parameters:
- NONCE_W, 32, nonce width.
- HASH_W, 24, hash/bounty width.
- LATENCIA, 2, cycles from nonce issue to the matching terminado/bounty. 0 means a purely combinational datapath.
- NONCE_MAX, 32'hFFFF_FFFF, last nonce issued.

Ports:
- clk  in  1  clock, rising edge.
- inicio  in  1  reset, asynchronous, active-low.
- arrancar  in  1  start pulse; honoured only in IDLE.
- terminado  in  1  hit flag from the comparator.
- bounty  in  HASH_W  hash from the comparator; meaningful only when terminado=1.
- nonce  out  NONCE_W  nonce currently driven into the datapath.
- buscando  out  1  high in BUSCANDO and DRENANDO.
- resultado_valido  out  1  result held for the consumer.
- resultado_leido  in  1  consumer ack.
- agotado  out  1  qualifies resultado_valido: no hit found.
- nonce_ganador  out  NONCE_W  winning nonce.
- hash_ganador  out  HASH_W  winning hash.

Behaviour:
- Reset (inicio=0, async):
  - state=IDLE.
  - nonce, nonce_ganador, hash_ganador = 0.
  - buscando, resultado_valido, agotado = 0.
  - Alignment delay line (LATENCIA entries of {valid, nonce}) cleared.
- Reset mid-search or mid-handshake aborts immediately; no result survives.
- Alignment: delay line shifts every cycle in BUSCANDO/DRENANDO.
  - Entry written = {1, nonce} in BUSCANDO, {0, x} in DRENANDO.
  - Aligned tag = delay-line output. For LATENCIA=0, aligned tag = {1, current nonce}.
  - A hit is terminado=1 AND aligned valid=1. terminado with aligned valid=0 is ignored.
- IDLE:
  - arrancar=1 -> BUSCANDO; nonce<=0; delay line cleared.
  - nonce_ganador, hash_ganador and agotado are cleared when leaving IDLE.
- BUSCANDO:
  - nonce increments by 1 each cycle.
  - Hit -> ENCONTRADO: capture aligned nonce and bounty; nonce freezes.
  - No hit and nonce==NONCE_MAX -> DRENANDO; nonce holds at NONCE_MAX. With LATENCIA=0, go straight to AGOTADO instead (the last nonce is checked that same cycle).
- DRENANDO:
  - A down-counter runs LATENCIA cycles.
  - Hit during drain -> ENCONTRADO (captures as above).
  - Counter expiry with no hit -> AGOTADO.
- ENCONTRADO:
  - resultado_valido=1, agotado=0.
  - Outputs stable until resultado_leido=1 is sampled -> IDLE; valid drops the next cycle.
- AGOTADO:
  - resultado_valido=1, agotado=1, nonce_ganador=0, hash_ganador=0.
  - Same ack rule as ENCONTRADO.
- Only the first hit counts; later terminado pulses are ignored until the next arrancar.
- arrancar outside IDLE: ignored.
- resultado_leido while resultado_valido=0: ignored.
- Hit on the same cycle nonce reaches NONCE_MAX: the hit wins (ENCONTRADO).
- All arithmetic is unsigned, width NONCE_W, with no wrap: nonce never exceeds NONCE_MAX.

Optional Feature:
- Macro: CONTROL_MINADO_CICLOS_EN.
- Defined:
  - Adds output ciclos (32 bits): cycles spent in BUSCANDO+DRENANDO for the current search.
  - Cleared on arrancar; saturates at 32'hFFFF_FFFF.
  - Frozen while resultado_valido=1; reset value 0.
- Undefined: no port and no counter logic.

Test Plan (LATENCIA=2 unless noted):
- Basic hit: arrancar at cycle 0, terminado=1 with bounty=24'h00_10_20 in the cycle where the aligned nonce is 5 -> resultado_valido=1, nonce_ganador=5, hash_ganador=24'h001020, agotado=0. After resultado_leido, valid drops one cycle later and state returns to IDLE.
- Spurious terminado in the first 2 cycles after arrancar (aligned valid=0) -> ignored; search continues and nonce keeps incrementing.
- Exhaustion, NONCE_MAX=7, terminado held 0 -> nonce stops at 7; after 2 drain cycles resultado_valido=1, agotado=1, nonce_ganador=0.
- Hit during drain, NONCE_MAX=7: terminado on the first drain cycle -> nonce_ganador=6 (the aligned nonce), agotado=0.
- Async reset asserted during ENCONTRADO before ack -> all outputs 0 at once, state IDLE; a later arrancar restarts from nonce 0.
- LATENCIA=0, CONTROL_MINADO_CICLOS_EN defined: terminado asserted when nonce=3 -> nonce_ganador=3, ciclos=4; second arrancar pulse during the handshake is ignored.

Source files
------------

// File: rtl/control_minado.sv
// control_minado: issues nonces to the hash datapath, aligns comparator hits with their nonce,
// and holds the first hit (or exhaustion) on a valid/ack handshake. `CONTROL_MINADO_CICLOS_EN adds ciclos.
module control_minado #(
  parameter int                 NONCE_W   = 32,
  parameter int                 HASH_W    = 24,
  parameter int                 LATENCIA  = 2,
  parameter logic [NONCE_W-1:0] NONCE_MAX = {NONCE_W{1'b1}}
) (
  input  logic               clk,
  input  logic               inicio,
  input  logic               arrancar,
  input  logic               terminado,
  input  logic [HASH_W-1:0]  bounty,
  output logic [NONCE_W-1:0] nonce,
  output logic               buscando,
  output logic               resultado_valido,
  input  logic               resultado_leido,
  output logic               agotado,
  output logic [NONCE_W-1:0] nonce_ganador,
  output logic [HASH_W-1:0]  hash_ganador
`ifdef CONTROL_MINADO_CICLOS_EN
  ,
  output logic [31:0]        ciclos
`endif
);
  localparam int LAT_N = (LATENCIA > 0) ? LATENCIA : 1;
  localparam int CNT_W = $clog2(LAT_N + 1);

  typedef enum logic [2:0] {IDLE, BUSCANDO, DRENANDO, ENCONTRADO, AGOTADO} state_t;

  state_t             state_q, state_d;
  logic [NONCE_W-1:0] nonce_q, nonce_d;
  logic [NONCE_W-1:0] ganador_q, ganador_d;
  logic [HASH_W-1:0]  hash_q, hash_d;
  logic               agotado_q, agotado_d;
  logic [CNT_W-1:0]   drain_q, drain_d;
  logic               al_vld;
  logic [NONCE_W-1:0] al_nonce;
  logic               activo, arranque, hit;

  assign activo   = (state_q == BUSCANDO) || (state_q == DRENANDO);
  assign arranque = (state_q == IDLE) && arrancar;
  assign hit      = activo && terminado && al_vld;

  // Tag pipeline mirroring the datapath latency; drain cycles push invalid tags.
  generate
    if (LATENCIA == 0) begin : g_comb
      assign al_vld   = 1'b1;
      assign al_nonce = nonce_q;
    end else begin : g_delay
      logic [LAT_N-1:0]   vld_q;
      logic [NONCE_W-1:0] tag_q [LAT_N];
      always_ff @(posedge clk or negedge inicio) begin
        if (!inicio) begin
          vld_q <= '0;
          for (int i = 0; i < LAT_N; i++) tag_q[i] <= '0;
        end else if (arranque) begin
          vld_q <= '0;
          for (int i = 0; i < LAT_N; i++) tag_q[i] <= '0;
        end else if (activo) begin
          vld_q[0] <= (state_q == BUSCANDO);
          tag_q[0] <= nonce_q;
          for (int i = 1; i < LAT_N; i++) begin
            vld_q[i] <= vld_q[i-1];
            tag_q[i] <= tag_q[i-1];
          end
        end
      end
      assign al_vld   = vld_q[LAT_N-1];
      assign al_nonce = tag_q[LAT_N-1];
    end
  endgenerate

  always_ff @(posedge clk or negedge inicio) begin
    if (!inicio) begin
      state_q   <= IDLE;
      nonce_q   <= '0;
      ganador_q <= '0;
      hash_q    <= '0;
      agotado_q <= 1'b0;
      drain_q   <= '0;
    end else begin
      state_q   <= state_d;
      nonce_q   <= nonce_d;
      ganador_q <= ganador_d;
      hash_q    <= hash_d;
      agotado_q <= agotado_d;
      drain_q   <= drain_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    nonce_d   = nonce_q;
    ganador_d = ganador_q;
    hash_d    = hash_q;
    agotado_d = agotado_q;
    drain_d   = drain_q;
    case (state_q)
      IDLE: begin
        if (arranque) begin
          state_d   = BUSCANDO;
          nonce_d   = '0;
          ganador_d = '0;
          hash_d    = '0;
          agotado_d = 1'b0;
        end
      end
      BUSCANDO: begin
        if (hit) begin
          state_d   = ENCONTRADO;
          ganador_d = al_nonce;
          hash_d    = bounty;
        end else if (nonce_q == NONCE_MAX) begin
          // Without pipeline latency the last nonce was already judged this cycle.
          if (LATENCIA == 0) begin
            state_d   = AGOTADO;
            agotado_d = 1'b1;
          end else begin
            state_d = DRENANDO;
            drain_d = CNT_W'(LAT_N - 1);
          end
        end else begin
          nonce_d = nonce_q + NONCE_W'(1);
        end
      end
      DRENANDO: begin
        if (hit) begin
          state_d   = ENCONTRADO;
          ganador_d = al_nonce;
          hash_d    = bounty;
        end else if (drain_q == '0) begin
          state_d   = AGOTADO;
          agotado_d = 1'b1;
        end else begin
          drain_d = drain_q - CNT_W'(1);
        end
      end
      ENCONTRADO, AGOTADO: begin
        if (resultado_leido) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign nonce            = nonce_q;
  assign buscando         = activo;
  assign resultado_valido = (state_q == ENCONTRADO) || (state_q == AGOTADO);
  assign agotado          = agotado_q;
  assign nonce_ganador    = ganador_q;
  assign hash_ganador     = hash_q;

`ifdef CONTROL_MINADO_CICLOS_EN
  logic [31:0] ciclos_q;
  always_ff @(posedge clk or negedge inicio) begin
    if (!inicio) begin
      ciclos_q <= '0;
    end else if (arranque) begin
      ciclos_q <= '0;
    end else if (activo && (ciclos_q != 32'hFFFF_FFFF)) begin
      ciclos_q <= ciclos_q + 32'd1;
    end
  end
  assign ciclos = ciclos_q;
`endif

endmodule

// File: tb/tb_control_minado.sv
// Bench for control_minado: LATENCIA=2/NONCE_MAX=7 instance driven from a vector table,
// plus a LATENCIA=0/NONCE_MAX=5 instance and hand-written reset/handshake sequences.
module tb_control_minado;
  logic        clk = 1'b0;
  logic        inicio;
  logic        arrancar_a, terminado_a, leido_a;
  logic [23:0] bounty_a;
  logic [31:0] nonce_a, ganador_a;
  logic [23:0] hash_a;
  logic        buscando_a, valido_a, agotado_a;
  logic        arrancar_b, terminado_b, leido_b;
  logic [23:0] bounty_b;
  logic [31:0] nonce_b, ganador_b;
  logic [23:0] hash_b;
  logic        buscando_b, valido_b, agotado_b;
`ifdef CONTROL_MINADO_CICLOS_EN
  logic [31:0] ciclos_a, ciclos_b;
`endif

  int n_checks = 0;
  int n_err    = 0;

  typedef struct {
    int          hit;   // aligned nonce on which terminado is raised, -1 = never
    bit          hold;  // terminado held high for the whole search
    bit          spur;  // terminado raised in the first two cycles as well
    logic [23:0] h;
    logic        ag;
    logic [31:0] n;
  } vec_t;

  typedef struct {
    logic        ag;
    logic [31:0] n;
    logic [23:0] h;
  } exp_t;

  exp_t sb[$];
  vec_t vecs[7];

  always #5 clk = ~clk;

  control_minado #(.NONCE_W(32), .HASH_W(24), .LATENCIA(2), .NONCE_MAX(32'd7)) dut_a (
    .clk(clk), .inicio(inicio), .arrancar(arrancar_a), .terminado(terminado_a),
    .bounty(bounty_a), .nonce(nonce_a), .buscando(buscando_a),
    .resultado_valido(valido_a), .resultado_leido(leido_a), .agotado(agotado_a),
    .nonce_ganador(ganador_a), .hash_ganador(hash_a)
`ifdef CONTROL_MINADO_CICLOS_EN
    , .ciclos(ciclos_a)
`endif
  );

  control_minado #(.NONCE_W(32), .HASH_W(24), .LATENCIA(0), .NONCE_MAX(32'd5)) dut_b (
    .clk(clk), .inicio(inicio), .arrancar(arrancar_b), .terminado(terminado_b),
    .bounty(bounty_b), .nonce(nonce_b), .buscando(buscando_b),
    .resultado_valido(valido_b), .resultado_leido(leido_b), .agotado(agotado_b),
    .nonce_ganador(ganador_b), .hash_ganador(hash_b)
`ifdef CONTROL_MINADO_CICLOS_EN
    , .ciclos(ciclos_b)
`endif
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic sb_check(input string nm, input logic ag, input logic [31:0] n, input logic [23:0] h);
    exp_t e;
    if (sb.size() == 0) begin
      n_checks++;
      n_err++;
      $display("FAIL %s: result produced with empty scoreboard", nm);
      return;
    end
    e = sb.pop_front();
    chk({nm, "_agotado"}, 64'(ag), 64'(e.ag));
    chk({nm, "_nonce_ganador"}, 64'(n), 64'(e.n));
    chk({nm, "_hash_ganador"}, 64'(h), 64'(e.h));
  endtask

  task automatic timeout(input string nm);
    if (sb.size() != 0) void'(sb.pop_front());
    n_checks++;
    n_err++;
    $display("FAIL %s: resultado_valido got 0 for 20 cycles, expected 1", nm);
  endtask

  task automatic run_a(input vec_t v);
    exp_t e;
    bit   done = 0;
    int   cyc  = 0;
    int   frz;
    e.ag = v.ag; e.n = v.n; e.h = v.h;
    sb.push_back(e);
    arrancar_a = 1'b1;
    step();
    arrancar_a = 1'b0;
    chk("a_buscando", 64'(buscando_a), 64'd1);
    for (int k = 0; k < 20 && !done; k++) begin
      terminado_a = v.hold || (v.hit >= 0 && k == v.hit + 2) || (v.spur && k < 2);
      bounty_a    = (v.hold || (v.hit >= 0 && k == v.hit + 2)) ? v.h : 24'($urandom);
      if (v.hit < 0 || k <= v.hit + 2) chk("a_nonce", 64'(nonce_a), 64'((k > 7) ? 7 : k));
      step();
      if (valido_a) begin
        done = 1;
        cyc  = k + 1;
      end
    end
    terminado_a = 1'b0;
    if (!done) begin
      timeout("a_result");
      return;
    end
    sb_check("a", agotado_a, ganador_a, hash_a);
    chk("a_latency", 64'(cyc), 64'((v.hit < 0) ? 10 : v.hit + 3));
    chk("a_buscando_off", 64'(buscando_a), 64'd0);
    frz = (v.hit < 0 || v.hit + 2 > 7) ? 7 : v.hit + 2;
    step();
    step();
    chk("a_hold_valid", 64'(valido_a), 64'd1);
    chk("a_hold_ganador", 64'(ganador_a), 64'(v.n));
    chk("a_nonce_frozen", 64'(nonce_a), 64'(frz));
    leido_a = 1'b1;
    step();
    leido_a = 1'b0;
    chk("a_valid_drop", 64'(valido_a), 64'd0);
  endtask

  task automatic run_b(input int hit, input logic [23:0] h, input logic ag,
                       input logic [31:0] n, input int lat);
    exp_t e;
    bit   done = 0;
    int   cyc  = 0;
    e.ag = ag; e.n = n; e.h = ag ? 24'd0 : h;
    sb.push_back(e);
    arrancar_b = 1'b1;
    step();
    arrancar_b = 1'b0;
    for (int k = 0; k < 20 && !done; k++) begin
      terminado_b = (k == hit);
      bounty_b    = h;
      if (k <= 5 && (hit < 0 || k <= hit)) chk("b_nonce", 64'(nonce_b), 64'(k));
      step();
      if (valido_b) begin
        done = 1;
        cyc  = k + 1;
      end
    end
    terminado_b = 1'b0;
    if (!done) begin
      timeout("b_result");
      return;
    end
    sb_check("b", agotado_b, ganador_b, hash_b);
    chk("b_latency", 64'(cyc), 64'(lat));
`ifdef CONTROL_MINADO_CICLOS_EN
    chk("b_ciclos", 64'(ciclos_b), 64'(lat));
`endif
    // A start request during the handshake must not disturb the held result.
    arrancar_b = 1'b1;
    step();
    arrancar_b = 1'b0;
    step();
    chk("b_arrancar_ignored_valid", 64'(valido_b), 64'd1);
    chk("b_arrancar_ignored_busc", 64'(buscando_b), 64'd0);
    chk("b_hold_ganador", 64'(ganador_b), 64'(n));
`ifdef CONTROL_MINADO_CICLOS_EN
    chk("b_ciclos_frozen", 64'(ciclos_b), 64'(lat));
`endif
    leido_b = 1'b1;
    step();
    leido_b = 1'b0;
    chk("b_valid_drop", 64'(valido_b), 64'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{5,  1'b0, 1'b0, 24'h001020, 1'b0, 32'd5};
    vecs[1] = '{4,  1'b0, 1'b1, 24'h0A0B0C, 1'b0, 32'd4};
    vecs[2] = '{-1, 1'b0, 1'b0, 24'h000000, 1'b1, 32'd0};
    vecs[3] = '{6,  1'b0, 1'b0, 24'h123456, 1'b0, 32'd6};
    vecs[4] = '{7,  1'b0, 1'b0, 24'h654321, 1'b0, 32'd7};
    vecs[5] = '{0,  1'b1, 1'b0, 24'h777777, 1'b0, 32'd0};
    vecs[6] = '{0,  1'b0, 1'b0, 24'hFEDCBA, 1'b0, 32'd0};

    inicio = 1'b0;
    arrancar_a = 0; terminado_a = 0; leido_a = 0; bounty_a = '0;
    arrancar_b = 0; terminado_b = 0; leido_b = 0; bounty_b = '0;
    step();
    step();
    chk("rst_nonce", 64'(nonce_a), 64'd0);
    chk("rst_valid", 64'(valido_a), 64'd0);
    chk("rst_buscando", 64'(buscando_a), 64'd0);
    chk("rst_agotado", 64'(agotado_a), 64'd0);
    chk("rst_ganador", 64'(ganador_a), 64'd0);
    chk("rst_hash", 64'(hash_a), 64'd0);
    inicio = 1'b1;
    step();

    // Ack while nothing is pending is a no-op.
    leido_a = 1'b1;
    step();
    leido_a = 1'b0;
    chk("idle_ack_valid", 64'(valido_a), 64'd0);
    chk("idle_ack_buscando", 64'(buscando_a), 64'd0);

    for (int i = 0; i < 7; i++) run_a(vecs[i]);

    // Reset while a result is held: everything clears immediately, no clock needed.
    arrancar_a = 1'b1;
    step();
    arrancar_a = 1'b0;
    for (int k = 0; k < 5; k++) begin
      terminado_a = (k == 4);
      bounty_a    = 24'hC0FFEE;
      step();
    end
    terminado_a = 1'b0;
    chk("pre_rst_valid", 64'(valido_a), 64'd1);
    #2 inicio = 1'b0;
    #1;
    chk("async_rst_valid", 64'(valido_a), 64'd0);
    chk("async_rst_nonce", 64'(nonce_a), 64'd0);
    chk("async_rst_ganador", 64'(ganador_a), 64'd0);
    chk("async_rst_hash", 64'(hash_a), 64'd0);
    chk("async_rst_agotado", 64'(agotado_a), 64'd0);
    chk("async_rst_buscando", 64'(buscando_a), 64'd0);
    step();
    inicio = 1'b1;
    step();
    chk("post_rst_valid", 64'(valido_a), 64'd0);
    arrancar_a = 1'b1;
    step();
    arrancar_a = 1'b0;
    chk("restart_nonce0", 64'(nonce_a), 64'd0);
    step();
    chk("restart_nonce1", 64'(nonce_a), 64'd1);
    #2 inicio = 1'b0;
    #1 inicio = 1'b1;
    step();

    run_b(3, 24'hABCDEF, 1'b0, 32'd3, 4);
    run_b(-1, 24'h000000, 1'b1, 32'd0, 6);
    run_b(5, 24'h13579B, 1'b0, 32'd5, 6);

    chk("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule
